// File: rtl/bitinfo_xtasks_parser_pkg.sv
// Shared definitions for the bitinfo accelerator-table parser: schedule-data
// field layout, error codes, FSM state and field-phase encodings.
package OmpSsManager;

    // Schedule-data word: {ACCID[47:40], COUNT[39:32], TASK_TYPE[31:0]}
    localparam int SCHED_TASKTYPE_BITS    = 32;
    localparam int SCHED_DATA_TASKTYPE_L  = 0;
    localparam int SCHED_DATA_COUNT_L     = 32;
    localparam int SCHED_DATA_COUNT_BITS  = 8;
    localparam int SCHED_DATA_ACCID_L     = 40;
    localparam int SCHED_DATA_ACCID_BITS  = 8;

    localparam logic [31:0] BITINFO_TERMINATOR = 32'hFFFF_FFFF;
    localparam logic [7:0]  ASCII_ZERO         = 8'h30;
    localparam logic [7:0]  ASCII_NINE         = 8'h39;

    typedef enum logic [1:0] {
        ERR_BAD_CHAR       = 2'd0,
        ERR_TOO_MANY_TYPES = 2'd1,
        ERR_TOO_MANY_ACCS  = 2'd2,
        ERR_ZERO_ACCS      = 2'd3
    } err_code_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_PARSE_TYPE,
        ST_PARSE_CNT,
        ST_CHECK_END,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } parse_state_e;

    // Which part of an entry the word in flight belongs to.
    typedef enum logic [1:0] {
        FLD_HEAD,
        FLD_TYPE,
        FLD_CNT
    } field_e;

    function automatic logic is_ascii_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/bitinfo_xtasks_parser_digit_acc.sv
// Decimal accumulator step: acc*10 + digit and ASCII digit check, purely combinational.
// Zero latency; no flow control, the caller decides when to commit acc_o.
module bitinfo_digit_acc
    import OmpSsManager::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [7:0]       char_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             ok_o
);

    logic [7:0] digit;

    assign digit = char_i - ASCII_ZERO;
    assign ok_o  = is_ascii_digit(char_i);
    // Multiply by ten as shift-add keeps this a single adder tree.
    assign acc_o = (acc_i << 3) + (acc_i << 1) + WIDTH'(digit);

endmodule

// File: rtl/bitinfo_xtasks_parser.sv
// Walks the ASCII bitinfo accelerator table and fills the scheduler type memory.
// One word read per FETCH with RD_LAT wait; one char per cycle; no backpressure on either port.
module bitinfo_xtasks_parser
    import OmpSsManager::*;
#(
    parameter int MAX_ACCS        = 16,
    parameter int MAX_ACC_TYPES   = 16,
    parameter int ACC_TYPE_BITS   = $clog2(MAX_ACC_TYPES),
    parameter int SCHED_DATA_BITS = 48,
    parameter int TYPE_DIGITS     = 19,
    parameter int NUM_DIGITS      = 3,
    parameter int HDR_WORDS       = 9,
    parameter int SKIP_WORDS      = 9,
    parameter int RD_LAT          = 1,
    parameter int AUTO_START      = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [1:0]                  err_code,
    output logic [ACC_TYPE_BITS:0]      num_types,
    output logic [$clog2(MAX_ACCS):0]   num_accs,
    output logic [31:0]                 bitinfo_addr,
    output logic                        bitinfo_en,
    input  logic [31:0]                 bitinfo_dout,
    output logic [ACC_TYPE_BITS-1:0]    scheduleData_portA_addr,
    output logic                        scheduleData_portA_en,
    output logic [SCHED_DATA_BITS-1:0]  scheduleData_portA_din
);

    localparam int NA_BITS   = $clog2(MAX_ACCS) + 1;
    localparam int CNT_BITS  = $clog2(10**NUM_DIGITS);
    localparam int MAX_DIGS  = (TYPE_DIGITS > NUM_DIGITS) ? TYPE_DIGITS : NUM_DIGITS;
    localparam int DIG_BITS  = $clog2(MAX_DIGS + 1);
    localparam int LAT_BITS  = $clog2(RD_LAT + 1);

    localparam logic [DIG_BITS-1:0]      TYPE_LAST  = DIG_BITS'(TYPE_DIGITS - 1);
    localparam logic [DIG_BITS-1:0]      CNT_LAST   = DIG_BITS'(NUM_DIGITS - 1);
    localparam logic [ACC_TYPE_BITS:0]   TYPES_FULL = (ACC_TYPE_BITS+1)'(MAX_ACC_TYPES);
    localparam logic [LAT_BITS-1:0]      LAT_INIT   = LAT_BITS'(RD_LAT - 1);

    parse_state_e                state_q;
    field_e                      fld_q;
    err_code_e                   err_code_q;
    logic [29:0]                 ptr_q;
    logic [31:0]                 word_q;
    logic [1:0]                  byte_q;
    logic [DIG_BITS-1:0]         dig_q;
    logic [LAT_BITS-1:0]         lat_q;
    logic [63:0]                 type_acc_q;
    logic [CNT_BITS-1:0]         cnt_acc_q;
    logic [ACC_TYPE_BITS:0]      num_types_q;
    logic [NA_BITS-1:0]          num_accs_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        error_q;
    logic                        en_q;
    logic                        auto_q;
    logic                        sched_en_q;
    logic [ACC_TYPE_BITS-1:0]    sched_addr_q;
    logic [SCHED_DATA_BITS-1:0]  sched_din_q;
    logic [SCHED_DATA_BITS-1:0]  sched_din_d;

    logic [7:0]          cur_char;
    logic [63:0]         type_acc_nxt;
    logic [CNT_BITS-1:0] cnt_acc_nxt;
    logic                type_ok;
    logic                cnt_ok;
    logic [31:0]         accs_sum;

    assign cur_char = word_q[{byte_q, 3'b000} +: 8];
    assign accs_sum = 32'(num_accs_q) + 32'(cnt_acc_q);

    bitinfo_digit_acc #(.WIDTH(64)) u_type_acc (
        .acc_i  (type_acc_q),
        .char_i (cur_char),
        .acc_o  (type_acc_nxt),
        .ok_o   (type_ok)
    );

    bitinfo_digit_acc #(.WIDTH(CNT_BITS)) u_cnt_acc (
        .acc_i  (cnt_acc_q),
        .char_i (cur_char),
        .acc_o  (cnt_acc_nxt),
        .ok_o   (cnt_ok)
    );

    always_comb begin
        sched_din_d = '0;
        sched_din_d[SCHED_DATA_ACCID_L +: SCHED_DATA_ACCID_BITS]   = SCHED_DATA_ACCID_BITS'(num_accs_q);
        sched_din_d[SCHED_DATA_COUNT_L +: SCHED_DATA_COUNT_BITS]   = SCHED_DATA_COUNT_BITS'(cnt_acc_q - 1'b1);
        sched_din_d[SCHED_DATA_TASKTYPE_L +: SCHED_TASKTYPE_BITS]  = type_acc_q[SCHED_TASKTYPE_BITS-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            fld_q        <= FLD_HEAD;
            err_code_q   <= ERR_BAD_CHAR;
            ptr_q        <= '0;
            word_q       <= '0;
            byte_q       <= '0;
            dig_q        <= '0;
            lat_q        <= '0;
            type_acc_q   <= '0;
            cnt_acc_q    <= '0;
            num_types_q  <= '0;
            num_accs_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            en_q         <= 1'b0;
            auto_q       <= (AUTO_START != 0);
            sched_en_q   <= 1'b0;
            sched_addr_q <= '0;
            sched_din_q  <= '0;
        end else begin
            en_q       <= 1'b0;
            sched_en_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start || auto_q) begin
                        auto_q      <= 1'b0;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        err_code_q  <= ERR_BAD_CHAR;
                        num_types_q <= '0;
                        num_accs_q  <= '0;
                        ptr_q       <= 30'(HDR_WORDS);
                        fld_q       <= FLD_HEAD;
                        byte_q      <= '0;
                        dig_q       <= '0;
                        type_acc_q  <= '0;
                        cnt_acc_q   <= '0;
                        busy_q      <= 1'b1;
                        en_q        <= 1'b1;
                        state_q     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    lat_q   <= LAT_INIT;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_q == '0) begin
                        word_q <= bitinfo_dout;
                        ptr_q  <= ptr_q + 30'd1;
                        byte_q <= '0;
                        case (fld_q)
                            FLD_HEAD: state_q <= ST_CHECK_END;
                            FLD_TYPE: state_q <= ST_PARSE_TYPE;
                            default:  state_q <= ST_PARSE_CNT;
                        endcase
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                ST_PARSE_TYPE: begin
                    if (!type_ok) begin
                        err_code_q <= ERR_BAD_CHAR;
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_ERR;
                    end else begin
                        type_acc_q <= type_acc_nxt;
                        // Count field always starts on a fresh word.
                        if (dig_q == TYPE_LAST) begin
                            dig_q   <= '0;
                            fld_q   <= FLD_CNT;
                            en_q    <= 1'b1;
                            state_q <= ST_FETCH;
                        end else begin
                            dig_q <= dig_q + 1'b1;
                            if (byte_q == 2'd3) begin
                                en_q    <= 1'b1;
                                state_q <= ST_FETCH;
                            end else begin
                                byte_q <= byte_q + 1'b1;
                            end
                        end
                    end
                end
                ST_PARSE_CNT: begin
                    if (!cnt_ok) begin
                        err_code_q <= ERR_BAD_CHAR;
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_ERR;
                    end else begin
                        cnt_acc_q <= cnt_acc_nxt;
                        if (dig_q == CNT_LAST) begin
                            dig_q   <= '0;
                            state_q <= ST_CHECK_END;
                        end else begin
                            dig_q <= dig_q + 1'b1;
                            if (byte_q == 2'd3) begin
                                en_q    <= 1'b1;
                                state_q <= ST_FETCH;
                            end else begin
                                byte_q <= byte_q + 1'b1;
                            end
                        end
                    end
                end
                ST_CHECK_END: begin
                    if (fld_q == FLD_HEAD) begin
                        if (word_q == BITINFO_TERMINATOR) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else if (num_types_q == TYPES_FULL) begin
                            err_code_q <= ERR_TOO_MANY_TYPES;
                            error_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= ST_ERR;
                        end else begin
                            fld_q   <= FLD_TYPE;
                            state_q <= ST_PARSE_TYPE;
                        end
                    end else if (cnt_acc_q == '0) begin
                        err_code_q <= ERR_ZERO_ACCS;
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_ERR;
                    end else if (accs_sum > 32'(MAX_ACCS)) begin
                        err_code_q <= ERR_TOO_MANY_ACCS;
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_ERR;
                    end else begin
                        sched_en_q   <= 1'b1;
                        sched_addr_q <= num_types_q[ACC_TYPE_BITS-1:0];
                        sched_din_q  <= sched_din_d;
                        state_q      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    num_types_q <= num_types_q + 1'b1;
                    num_accs_q  <= num_accs_q + NA_BITS'(cnt_acc_q);
                    ptr_q       <= ptr_q + 30'(SKIP_WORDS);
                    fld_q       <= FLD_HEAD;
                    byte_q      <= '0;
                    dig_q       <= '0;
                    type_acc_q  <= '0;
                    cnt_acc_q   <= '0;
                    en_q        <= 1'b1;
                    state_q     <= ST_FETCH;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy                    = busy_q;
    assign done                    = done_q;
    assign error                   = error_q;
    assign err_code                = err_code_q;
    assign num_types               = num_types_q;
    assign num_accs                = num_accs_q;
    assign bitinfo_addr            = {ptr_q, 2'b00};
    assign bitinfo_en              = en_q;
    assign scheduleData_portA_addr = sched_addr_q;
    assign scheduleData_portA_en   = sched_en_q;
    assign scheduleData_portA_din  = sched_din_q;

endmodule

// File: doc/bitinfo_xtasks_parser.md
BITINFO_XTASKS_PARSER -- requirements
Module: bitinfo_xtasks_parser

Interface
REQ-001 SHALL have parameter MAX_ACCS, default 16: maximum total accelerator instances.
REQ-002 SHALL have parameter MAX_ACC_TYPES, default 16: maximum accelerator type entries.
REQ-003 SHALL have parameter ACC_TYPE_BITS, default $clog2(MAX_ACC_TYPES): schedule-data address width.
REQ-004 SHALL have parameter SCHED_DATA_BITS, default 48: schedule-data word width.
REQ-005 SHALL have parameters TYPE_DIGITS, default 19, and NUM_DIGITS, default 3: ASCII digits per type and count field.
REQ-006 SHALL have parameters HDR_WORDS, default 9, and SKIP_WORDS, default 9: words before the first entry, and words skipped after the count field.
REQ-007 SHALL have parameter RD_LAT, default 1: cycles from bitinfo_en to valid bitinfo_dout.
REQ-008 SHALL have parameter AUTO_START, default 1: parse once after reset release without a start pulse.
REQ-009 Ports (name direction width meaning):
  clk  in  1  single clock, all logic on rising edge.
  rstn  in  1  reset, asynchronous, active-low.
  start  in  1  one-cycle re-parse request.
  busy  out  1  parse in progress.
  done  out  1  parse completed without error; level until next start.
  error  out  1  parse aborted; level until next start.
  err_code  out  2  0 bad char, 1 too many types, 2 too many instances, 3 zero instances.
  num_types  out  ACC_TYPE_BITS+1  entries written.
  num_accs  out  $clog2(MAX_ACCS)+1  instances assigned.
  bitinfo_addr  out  32  byte address, word aligned, bits [1:0]=0.
  bitinfo_en  out  1  read enable.
  bitinfo_dout  in  32  read data.
  scheduleData_portA_addr  out  ACC_TYPE_BITS  entry index.
  scheduleData_portA_en  out  1  write strobe.
  scheduleData_portA_din  out  SCHED_DATA_BITS  packed entry.

Function
REQ-010 Entry layout: TYPE_WORDS=ceil((TYPE_DIGITS+1)/4) words of type field, CNT_WORDS=ceil((NUM_DIGITS+1)/4) words of count field, SKIP_WORDS skipped; characters little-endian, char 0 in bits [7:0].
REQ-011 States: IDLE, FETCH, WAIT, PARSE_TYPE, PARSE_CNT, CHECK_END, WRITE, DONE, ERR.
REQ-012 start in IDLE/DONE/ERR: clear done, error, counters; word pointer=HDR_WORDS; enter FETCH next cycle; start while busy ignored.
REQ-013 FETCH asserts bitinfo_en exactly one cycle; WAIT holds RD_LAT cycles, then registers bitinfo_dout.
REQ-014 Per entry, first fetched word: 32'hFFFFFFFF -> DONE; else enter PARSE_TYPE.
REQ-015 Each parse cycle consumes one char: acc <= acc*10 + (char-8'h30), single cycle, shift-add permitted.
REQ-016 Char outside 8'h30..8'h39 within a digit field -> ERR, err_code=0, no write.
REQ-017 Type accumulator 64 bits; count accumulator $clog2(10**NUM_DIGITS) bits; overflow impossible by construction.
REQ-018 Chars after the last digit of a field in its final word are ignored; fields restart at byte 0 of a new word.
REQ-019 Count==0 -> ERR code 3; num_accs+count>MAX_ACCS -> ERR code 2; num_types==MAX_ACC_TYPES at a non-terminator entry -> ERR code 1.
REQ-020 WRITE: one-cycle en; addr=num_types; din ACCID field=num_accs, COUNT field=count-1, TASK_TYPE field=type[SCHED_TASKTYPE_BITS-1:0], other bits 0.
REQ-021 After WRITE: num_types+=1, num_accs+=count, pointer+=CNT_WORDS+SKIP_WORDS, then FETCH.
REQ-022 bitinfo_addr = pointer<<2, pointer incremented per fetched word.
REQ-023 busy high in every state except IDLE, DONE, ERR.

Reset
REQ-024 rstn low: state IDLE, all outputs and counters 0, bitinfo_en and scheduleData_portA_en low, asynchronously.
REQ-025 Reset mid-parse abandons parse; no write strobe after reset assertion; entries already written remain in the schedule memory.
REQ-026 AUTO_START=1: behave as start on first clk edge after rstn rises.

Structure
REQ-027 SCHED_DATA_* field positions, SCHED_TASKTYPE_BITS and the err_code enumeration SHALL live in OmpSsManager package.
REQ-028 Sub-module bitinfo_digit_acc (parametrised width: accumulate, digit check) SHALL be instantiated for type and count fields.

Verification
REQ-029 Default params, one entry type 0000000000000001234, count 004, then FFFFFFFF -> one write addr 0, ACCID 0, COUNT 3, type 1234; done=1, num_accs=4.
REQ-030 Three entries counts 2,3,1 -> ACCID 0,2,5; num_types=3, num_accs=6.
REQ-031 Count field "0A1" -> error=1, err_code=0, no write.
REQ-032 Counts 10 then 7 with MAX_ACCS=16 -> first write only, err_code=2.
REQ-033 RD_LAT=3, rstn pulsed mid-PARSE_TYPE -> outputs 0 immediately; auto re-parse yields results identical to an uninterrupted run.
REQ-034 start during busy ignored; start after done re-parses with identical writes.
